wbu_word_serializer: RTL



---
 rtl/wbu_serial_pkg.sv | 34 +++
 rtl/wbu_sextet_to_ascii.sv | 11 +
 rtl/wbu_word_serializer.sv | 110 +++++++++++
 3 files changed

// File: rtl/wbu_serial_pkg.sv
// Shared types, constants and code-mapping helpers for the debug-bus
// return-path word serializer.
package wbu_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    NL   = 2'd2
  } state_t;

  localparam logic [7:0] NL_CHAR = 8'h0a;
  localparam int         CW_BITS = 36;
  localparam int         SX_BITS = 6;

  // Number of sextets carried by a codeword, decoded from its top three bits.
  function automatic logic [3:0] cw_len(input logic [2:0] hdr);
    if (!hdr[2])      return 4'd6;
    else if (!hdr[1]) return 4'd2;
    else if (!hdr[0]) return 4'd3;
    else              return 4'd1;
  endfunction

  // Printable encoding: digits, upper case, lower case, then '@' and '%'.
  function automatic logic [7:0] sx2ascii(input logic [5:0] s);
    logic [7:0] w;
    w = {2'b00, s};
    if (s < 6'd10)       return 8'h30 + w;
    else if (s < 6'd36)  return 8'h41 + (w - 8'd10);
    else if (s < 6'd62)  return 8'h61 + (w - 8'd36);
    else if (s == 6'd62) return 8'h40;
    else                 return 8'h25;
  endfunction

endpackage

// File: rtl/wbu_sextet_to_ascii.sv
// Combinational sextet-to-character mapper.
module wbu_sextet_to_ascii
  import wbu_serial_pkg::*;
(
  input  logic [SX_BITS-1:0] i_sextet,
  output logic [7:0]         o_char
);

  assign o_char = sx2ascii(i_sextet);

endmodule

// File: rtl/wbu_word_serializer.sv
// Pops 36-bit codewords from the return FIFO, emits their sextets MSB-first
// as printable characters over a stb/busy handshake, and appends a single
// newline each time the FIFO drains after traffic.
module wbu_word_serializer
  import wbu_serial_pkg::*;
#(
  parameter bit NL_EN  = 1'b1,
  parameter int LGIDLE = 0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_stb,
  input  logic [CW_BITS-1:0] i_word,
  output logic               o_rd,
  output logic               o_stb,
  output logic [7:0]         o_char,
  input  logic               i_busy,
  output logic               o_busy
);

  if (LGIDLE != 0) begin : g_lgidle_reserved
    $error("LGIDLE is reserved and must be 0");
  end

  state_t                     state_p1;
  logic [CW_BITS-SX_BITS-1:0] rest_p1;
  logic [3:0]                 cnt_p1;
  logic                       nl_pending_p1;
  logic [SX_BITS-1:0]         sx_nxt;
  logic [7:0]                 char_nxt;
  logic                       accept;

  assign o_rd   = i_stb && (state_p1 == IDLE) && !i_rst;
  assign accept = o_stb && !i_busy;

  // The head sextet comes straight from the FIFO on a pop; afterwards it is
  // the top of the remaining bits, so each accept can load the next char
  // without a bubble.
  assign sx_nxt = (state_p1 == IDLE) ? i_word[CW_BITS-1 -: SX_BITS]
                                     : rest_p1[CW_BITS-SX_BITS-1 -: SX_BITS];

  wbu_sextet_to_ascii u_map (
    .i_sextet (sx_nxt),
    .o_char   (char_nxt)
  );

  // Serializer control: pop, sextet walk, optional trailing newline.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_p1      <= IDLE;
      o_stb         <= 1'b0;
      o_char        <= 8'h00;
      o_busy        <= 1'b0;
      cnt_p1        <= 4'd0;
      nl_pending_p1 <= 1'b0;
    end else begin
      case (state_p1)
        IDLE: begin
          if (o_rd) begin
            rest_p1       <= i_word[CW_BITS-SX_BITS-1:0];
            cnt_p1        <= cw_len(i_word[CW_BITS-1 -: 3]);
            nl_pending_p1 <= NL_EN;
            o_char        <= char_nxt;
            o_stb         <= 1'b1;
            o_busy        <= 1'b1;
            state_p1      <= SEND;
          end
        end
        SEND: begin
          if (accept) begin
            if (cnt_p1 > 4'd1) begin
              rest_p1 <= {rest_p1[CW_BITS-2*SX_BITS-1:0], {SX_BITS{1'b0}}};
              o_char  <= char_nxt;
              cnt_p1  <= cnt_p1 - 4'd1;
            end else begin
              cnt_p1 <= 4'd0;
              if (i_stb) begin
                // More traffic queued: skip the newline, pop next cycle.
                state_p1 <= IDLE;
                o_stb    <= 1'b0;
                o_busy   <= 1'b0;
              end else if (nl_pending_p1) begin
                state_p1 <= NL;
                o_char   <= NL_CHAR;
              end else begin
                state_p1 <= IDLE;
                o_stb    <= 1'b0;
                o_busy   <= 1'b0;
              end
            end
          end
        end
        NL: begin
          if (accept) begin
            nl_pending_p1 <= 1'b0;
            state_p1      <= IDLE;
            o_stb         <= 1'b0;
            o_busy        <= 1'b0;
          end
        end
        default: begin
          state_p1 <= IDLE;
          o_stb    <= 1'b0;
          o_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
